// File: rtl/alu_arbiter.sv
// Two-requester arbiter feeding one shared combinational ALU, one operation in flight.
// Latency: accept in IDLE, ALU result captured one cycle later, response valid the cycle after.
// Backpressure: response held in RESP until rsp_ready; no requester is readied outside IDLE.
module alu_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [2:0] req0_sel,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [2:0] req1_sel,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [7:0] alu_out,
  input  logic       alu_carry,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic       rsp_carry,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next_state;

  logic       r_last_grant;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [2:0] r_sel;
  logic       r_id;
  logic [7:0] r_rsp_data;
  logic       r_rsp_id;
  logic       r_rsp_carry;

  logic       w_any_vld;
  logic       w_grant;
  logic       w_accept;

  // Grant selection: lone requester wins; on contention alternate or favour requester 0.
  always_comb begin
    w_any_vld = req0_valid | req1_valid;
    w_grant   = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = RR_EN ? ~r_last_grant : 1'b0;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end
  end

  // Ready equals grant in IDLE, so any valid request in IDLE is a handshake.
  assign w_accept = (r_state == ST_IDLE) && w_any_vld;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake outputs; readies are gated by reset so they drop immediately.
  always_comb begin
    w_next_state = r_state;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp_valid    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy       = 1'b0;
        req0_ready = reset_n & w_any_vld & ~w_grant;
        req1_ready = reset_n & w_any_vld & w_grant;
        if (w_any_vld) begin
          w_next_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_next_state = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Capture the granted operation; the ALU only ever sees these registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a          <= 8'h00;
      r_b          <= 8'h00;
      r_sel        <= 3'b000;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_a          <= w_grant ? req1_a : req0_a;
      r_b          <= w_grant ? req1_b : req0_b;
      r_sel        <= w_grant ? req1_sel : req0_sel;
      r_id         <= w_grant;
      r_last_grant <= w_grant;
    end
  end

  // Latch the ALU result at the end of EXEC; carry only meaningful for add/sub.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_data  <= 8'h00;
      r_rsp_id    <= 1'b0;
      r_rsp_carry <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_rsp_data  <= alu_out;
      r_rsp_id    <= r_id;
      r_rsp_carry <= (r_sel[2:1] == 2'b00) ? alu_carry : 1'b0;
    end
  end

  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_sel   = r_sel;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign rsp_carry = r_rsp_carry;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: round-robin and fixed-priority instances share request stimulus,
// each with its own reference ALU; hand-computed expectations checked through one task.
module tb_alu_arbiter;

  logic       clk;
  logic       reset_n;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_sel, req1_sel;
  logic       rsp_ready;
  logic       force_carry;

  logic       rr_req0_ready, rr_req1_ready, rr_alu_carry, rr_rsp_valid, rr_rsp_id, rr_rsp_carry, rr_busy;
  logic [7:0] rr_alu_a, rr_alu_b, rr_alu_out, rr_rsp_data;
  logic [2:0] rr_alu_sel;
  logic [8:0] rr_res;

  logic       fp_req0_ready, fp_req1_ready, fp_alu_carry, fp_rsp_valid, fp_rsp_id, fp_rsp_carry, fp_busy;
  logic [7:0] fp_alu_a, fp_alu_b, fp_alu_out, fp_rsp_data;
  logic [2:0] fp_alu_sel;
  logic [8:0] fp_res;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;
  bit fp_r1_seen;

  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    case (s)
      3'b000:  alu_f = {1'b0, a} + {1'b0, b};
      3'b001:  alu_f = {1'b0, a} - {1'b0, b};
      3'b010:  alu_f = {1'b0, a & b};
      3'b011:  alu_f = {1'b0, a | b};
      3'b100:  alu_f = {1'b0, a ^ b};
      3'b101:  alu_f = {1'b0, ~(a ^ b)};
      3'b110:  alu_f = {1'b0, ~(a & b)};
      default: alu_f = {1'b0, ~(a | b)};
    endcase
  endfunction

  assign rr_res       = alu_f(rr_alu_a, rr_alu_b, rr_alu_sel);
  assign rr_alu_out   = rr_res[7:0];
  assign rr_alu_carry = rr_res[8] | force_carry;
  assign fp_res       = alu_f(fp_alu_a, fp_alu_b, fp_alu_sel);
  assign fp_alu_out   = fp_res[7:0];
  assign fp_alu_carry = fp_res[8] | force_carry;

  alu_arbiter #(.RR_EN(1'b1)) dut_rr (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(rr_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(rr_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(rr_alu_a), .alu_b(rr_alu_b), .alu_sel(rr_alu_sel), .alu_out(rr_alu_out), .alu_carry(rr_alu_carry),
    .rsp_valid(rr_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rr_rsp_id), .rsp_data(rr_rsp_data),
    .rsp_carry(rr_rsp_carry), .busy(rr_busy)
  );

  alu_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_sel(fp_alu_sel), .alu_out(fp_alu_out), .alu_carry(fp_alu_carry),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id), .rsp_data(fp_rsp_data),
    .rsp_carry(fp_rsp_carry), .busy(fp_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watch for the fixed-priority instance ever readying requester 1.
  always @(negedge clk) begin
    if (!mon_en) fp_r1_seen <= 1'b0;
    else if (fp_req1_ready) fp_r1_seen <= 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_rsp(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (rr_rsp_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_op(input logic which, input logic [7:0] a, input logic [7:0] b, input logic [2:0] s,
                        input logic [7:0] ed, input logic ec, input string tag);
    @(negedge clk);
    if (which) begin
      req1_a = a; req1_b = b; req1_sel = s; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_sel = s; req0_valid = 1'b1;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check({tag, "_exec"}, {30'd0, rr_busy, rr_rsp_valid}, 32'd2);
    check({tag, "_alu_a"}, rr_alu_a, a);
    @(posedge clk); #1;
    check({tag, "_vld"}, rr_rsp_valid, 1);
    check({tag, "_data"}, rr_rsp_data, ed);
    check({tag, "_carry"}, rr_rsp_carry, ec);
    check({tag, "_id"}, rr_rsp_id, which);
    @(posedge clk); #1;
    check({tag, "_done"}, {30'd0, rr_busy, rr_rsp_valid}, 32'd0);
  endtask

  initial begin
    bit ok;
    bit seen;
    reset_n = 1'b0;
    req0_a = 8'h00; req0_b = 8'h00; req0_sel = 3'b000;
    req1_a = 8'h00; req1_b = 8'h00; req1_sel = 3'b000;
    rsp_ready = 1'b1;
    force_carry = 1'b0;
    // Valids high during reset: readies must still be low.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", rr_busy, 0);
    check("rst_rsp_valid", rr_rsp_valid, 0);
    check("rst_ready0", rr_req0_ready, 0);
    check("rst_ready1", rr_req1_ready, 0);
    check("rst_data", rr_rsp_data, 0);
    check("rst_id_carry", {rr_rsp_id, rr_rsp_carry}, 0);
    check("rst_alu", {rr_alu_a, rr_alu_b, rr_alu_sel}, 0);

    // First cycle after release: requester 0 wins contention in both modes.
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("first_rr_r0", rr_req0_ready, 1);
    check("first_rr_r1", rr_req1_ready, 0);
    check("first_fp_r0", fp_req0_ready, 1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    run_op(1'b0, 8'h80, 8'h80, 3'b000, 8'h00, 1'b1, "add_ovf");
    force_carry = 1'b1;
    run_op(1'b0, 8'hF0, 8'h3C, 3'b010, 8'h30, 1'b0, "and_fc");
    force_carry = 1'b0;
    run_op(1'b0, 8'hAA, 8'h0F, 3'b101, 8'h5A, 1'b0, "xnor");
    run_op(1'b1, 8'h05, 8'h0A, 3'b001, 8'hFB, 1'b1, "sub_brw");

    // Continuous contention for six operations.
    @(negedge clk);
    req0_a = 8'h11; req0_b = 8'h22; req0_sel = 3'b000;
    req1_a = 8'h50; req1_b = 8'h05; req1_sel = 3'b011;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_rsp(8, ok);
      check("rr_timeout", ok, 1);
      check("rr_id", rr_rsp_id, i % 2);
      check("rr_data", rr_rsp_data, (i % 2) ? 8'h55 : 8'h33);
      check("fp_vld", fp_rsp_valid, 1);
      check("fp_id", fp_rsp_id, 0);
      check("fp_data", fp_rsp_data, 8'h33);
      if (i == 5) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    mon_en = 1'b0;
    check("fp_r1_never", fp_r1_seen, 0);

    // Response stall with operand churn.
    @(negedge clk);
    req1_a = 8'hC3; req1_b = 8'h5A; req1_sel = 3'b100;
    req1_valid = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    req1_a = ~req1_a; req1_b = ~req1_b; req1_sel = ~req1_sel;
    check("stall_exec_busy", rr_busy, 1);
    check("stall_exec_alu", {rr_alu_a, rr_alu_b, rr_alu_sel}, {8'hC3, 8'h5A, 3'b100});
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      check("stall_vld", rr_rsp_valid, 1);
      check("stall_data", rr_rsp_data, 8'h99);
      check("stall_id_carry", {rr_rsp_id, rr_rsp_carry}, 2'b10);
      check("stall_alu", {rr_alu_a, rr_alu_b, rr_alu_sel}, {8'hC3, 8'h5A, 3'b100});
      check("stall_ready0", rr_req0_ready, 0);
      check("stall_busy", rr_busy, 1);
      req1_a = ~req1_a; req1_b = ~req1_b; req1_sel = ~req1_sel;
      if (i == 1) begin
        req0_a = 8'h0F; req0_b = 8'h01; req0_sel = 3'b000;
        req0_valid = 1'b1;
      end
      if (i == 3) rsp_ready = 1'b1;
      @(posedge clk); #1;
    end
    check("stall_done_vld", rr_rsp_valid, 0);
    check("stall_done_busy", rr_busy, 0);
    check("idle_ready0", rr_req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    check("next_alu_a", rr_alu_a, 8'h0F);
    @(posedge clk); #1;
    check("next_vld", rr_rsp_valid, 1);
    check("next_data", rr_rsp_data, 8'h10);
    check("next_id", rr_rsp_id, 0);
    @(posedge clk); #1;

    // Reset pulse in EXEC discards the operation.
    @(negedge clk);
    req0_a = 8'hFF; req0_b = 8'h01; req0_sel = 3'b000;
    req0_valid = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    check("mid_exec_busy", rr_busy, 1);
    #1 reset_n = 1'b0;
    #1;
    check("arst_busy", rr_busy, 0);
    check("arst_vld", rr_rsp_valid, 0);
    check("arst_data", rr_rsp_data, 0);
    check("arst_alu", {rr_alu_a, rr_alu_b, rr_alu_sel}, 0);
    check("arst_ready", {rr_req0_ready, rr_req1_ready}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (rr_rsp_valid || rr_busy) seen = 1'b1;
    end
    check("no_rsp_after_rst", seen, 0);
    @(negedge clk);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("post_rst_r0", rr_req0_ready, 1);
    check("post_rst_r1", rr_req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_vld", rr_rsp_valid, 1);
    check("post_rst_id", rr_rsp_id, 0);
    check("post_rst_data", {rr_rsp_carry, rr_rsp_data}, 9'h100);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
